image_receiver: RTL

UART receiver for the image link: the receiving end of the camera image stream sent by `image_sender`, for the base-station/bench FPGA that reconstructs frames. It deserialises 8N1 bytes and synchronises on the inter-frame idle gap plus the start-pixel marker. It reassembles 12-bit RGB444 pixels and emits one buffer write per pixel, with addresses 0..NUM_PIXELS-1, into a 320x240 frame RAM.

---
 rtl/image_receiver.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/image_receiver.sv
// UART image-link receiver: 8N1 byte RX, gap + marker framing, RGB444 pixel writes.
// Optional stop-bit framing check enabled by defining IMAGE_RX_FRAMING_CHECK_EN.
//
// rx state | meaning
// RX_IDLE  | waiting for falling edge of start bit
// RX_START | half-bit wait, confirm start bit low
// RX_DATA  | 8 data samples, LSB first
// RX_STOP  | stop-bit sample, emits byte_valid
// RX_WAIT  | bad stop bit, wait for line high
//
// fr state | meaning
// HUNT     | discard bytes until an idle gap
// ARMED    | gap seen, expect marker byte 0x00
// MARK_LO  | expect marker byte 0x0A
// PIX_HI   | expect pixel high byte {4'h0, r}
// PIX_LO   | expect pixel low byte {g, b}, write pixel
module image_receiver #(
  parameter int NUM_PIXELS  = 76800,
  parameter int BAUD_RATE   = 115200,
  parameter int CLOCK_SPEED = 50_000_000,
  parameter int IDLE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_in,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
  localparam logic [16:0]   ADDR_LAST = 17'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [2:0] {HUNT, ARMED, MARK_LO, PIX_HI, PIX_LO} fr_state_t;

  logic rx_meta, rx_sync, rx_prev;
  logic [IW-1:0] idle_cnt;
  logic gap;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      idle_cnt <= '0;
    end else begin
      rx_meta <= uart_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (!rx_sync)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign gap = (idle_cnt == IDLE_MAX);

  rx_state_t rx_state, rx_next;
  logic [TW-1:0] tmr, tmr_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] rx_byte, byte_n;
  logic byte_valid, valid_n;
  logic accept, bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      tmr        <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      tmr        <= tmr_n;
      bit_cnt    <= bit_n;
      rx_byte    <= byte_n;
      byte_valid <= valid_n;
    end
  end

`ifdef IMAGE_RX_FRAMING_CHECK_EN
  logic stop_ok, stop_n;

  always_ff @(posedge clk) begin
    if (rst) stop_ok <= 1'b1;
    else     stop_ok <= stop_n;
  end

  assign accept = byte_valid & stop_ok;
  assign bad    = byte_valid & ~stop_ok;
`else
  assign accept = byte_valid;
  assign bad    = 1'b0;
`endif

  always_comb begin
    rx_next = rx_state;
    tmr_n   = tmr;
    bit_n   = bit_cnt;
    byte_n  = rx_byte;
    valid_n = 1'b0;
`ifdef IMAGE_RX_FRAMING_CHECK_EN
    stop_n  = stop_ok;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_next = RX_START;
          tmr_n   = HALF_LAST;
        end
      end
      RX_START: begin
        if (tmr == '0) begin
          rx_next = rx_sync ? RX_IDLE : RX_DATA;
          tmr_n   = BIT_LAST;
          bit_n   = '0;
        end else tmr_n = tmr - 1'b1;
      end
      RX_DATA: begin
        if (tmr == '0) begin
          byte_n = {rx_sync, rx_byte[7:1]};
          tmr_n  = BIT_LAST;
          bit_n  = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) rx_next = RX_STOP;
        end else tmr_n = tmr - 1'b1;
      end
      RX_STOP: begin
        if (tmr == '0) begin
          valid_n = 1'b1;
`ifdef IMAGE_RX_FRAMING_CHECK_EN
          stop_n  = rx_sync;
          rx_next = rx_sync ? RX_IDLE : RX_WAIT;
`else
          rx_next = RX_IDLE;
`endif
        end else tmr_n = tmr - 1'b1;
      end
      RX_WAIT: if (rx_sync) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  fr_state_t fr_state, fr_next;
  logic [3:0]  hi, hi_n;
  logic [16:0] addr_n;
  logic [11:0] data_n;
  logic wr_en_n, done_n, err_n, busy_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      fr_state   <= HUNT;
      hi         <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fr_state   <= fr_next;
      hi         <= hi_n;
      wr_en      <= wr_en_n;
      wr_addr    <= addr_n;
      wr_data    <= data_n;
      frame_done <= done_n;
      frame_err  <= err_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    fr_next = fr_state;
    hi_n    = hi;
    addr_n  = wr_addr;
    data_n  = wr_data;
    wr_en_n = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    busy_n  = busy;
    // Address advances the cycle after its write so it stays stable during wr_en.
    if (wr_en && !frame_done) addr_n = wr_addr + 1'b1;
    if (gap) begin
      fr_next = ARMED;
      if (busy) begin
        err_n  = 1'b1;
        busy_n = 1'b0;
      end
    end else if (bad) begin
      fr_next = HUNT;
      if (busy) begin
        err_n  = 1'b1;
        busy_n = 1'b0;
      end
    end else if (accept) begin
      case (fr_state)
        HUNT:  fr_next = HUNT;
        ARMED: fr_next = (rx_byte == 8'h00) ? MARK_LO : HUNT;
        MARK_LO: begin
          if (rx_byte == 8'h0A) begin
            addr_n  = '0;
            busy_n  = 1'b1;
            fr_next = PIX_HI;
          end else fr_next = HUNT;
        end
        PIX_HI: begin
          if (rx_byte[7:4] == 4'h0) begin
            hi_n    = rx_byte[3:0];
            fr_next = PIX_LO;
          end else begin
            err_n   = 1'b1;
            busy_n  = 1'b0;
            fr_next = HUNT;
          end
        end
        PIX_LO: begin
          wr_en_n = 1'b1;
          data_n  = {hi, rx_byte};
          if (wr_addr == ADDR_LAST) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            fr_next = HUNT;
          end else fr_next = PIX_HI;
        end
        default: fr_next = HUNT;
      endcase
    end
  end

endmodule
